// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register carrying data, instruction
// and control fields, with a saturating back-pressure cycle counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer with
// registered in_ready. Without it, the stage is a single entry with in_ready
// derived combinationally from out_ready.
module pipe_stage_reg #(
    parameter int DATA_W  = 24,
    parameter int INSTR_W = 19,
    parameter int CTRL_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [15:0]        stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
`else
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;
`endif

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
    logic [15:0]        stall_q, stall_d;
    logic               accept;
    logic               out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic               in_ready_q, in_ready_d;
    logic [DATA_W-1:0]  skid_data_q,  skid_data_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [CTRL_W-1:0]  skid_ctrl_q,  skid_ctrl_d;

    assign in_ready = in_ready_q;
`else
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = data_q;
    assign out_instr = instr_q;
    assign out_ctrl  = ctrl_q;
    assign stall_cnt = stall_q;

    // Flush suppresses both handshakes for the cycle it is asserted.
    assign accept   = in_valid && in_ready && !flush;
    assign out_xfer = out_valid && out_ready && !flush;

    // Next-state, payload and stall-counter computation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        instr_d = instr_q;
        ctrl_d  = ctrl_q;
        stall_d = stall_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d  = skid_data_q;
        skid_instr_d = skid_instr_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        data_d  = in_data;
                        instr_d = in_instr;
                        ctrl_d  = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && out_xfer) begin
                        data_d  = in_data;
                        instr_d = in_instr;
                        ctrl_d  = in_ctrl;
                    end else if (accept) begin
                        // Main entry is stalled: park the newcomer behind it.
                        state_d      = ST_TWO;
                        skid_data_d  = in_data;
                        skid_instr_d = in_instr;
                        skid_ctrl_d  = in_ctrl;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        data_d  = skid_data_q;
                        instr_d = skid_instr_q;
                        ctrl_d  = skid_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // in_ready is registered, so it reflects room after this edge.
        in_ready_d = (state_d != ST_TWO);
`else
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
            data_d  = in_data;
            instr_d = in_instr;
            ctrl_d  = in_ctrl;
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
`endif

        if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State, payload and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            instr_q <= '0;
            ctrl_q  <= '0;
            stall_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q   <= 1'b1;
            skid_data_q  <= '0;
            skid_instr_q <= '0;
            skid_ctrl_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q   <= in_ready_d;
            skid_data_q  <= skid_data_d;
            skid_instr_q <= skid_instr_d;
            skid_ctrl_q  <= skid_ctrl_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver pushes each accepted
// payload into a queue, a negedge monitor pops and compares every output
// transfer. Directed checks cover reset, streaming, stall, flush, reset
// during stall and stall-counter saturation.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 24;
    localparam int INSTR_W = 19;
    localparam int CTRL_W  = 2;
    localparam int PW      = DATA_W + INSTR_W + CTRL_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [INSTR_W-1:0] in_instr;
    logic [CTRL_W-1:0]  in_ctrl;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [INSTR_W-1:0] out_instr;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [15:0]        stall_cnt;

    logic [PW-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .INSTR_W(INSTR_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_instr (in_instr),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_instr(out_instr),
        .out_ctrl (out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: record accepted payloads, forget discarded ones.
    task automatic step();
        @(negedge clk);
        if (!reset || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_instr, in_data, in_ctrl});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [INSTR_W-1:0] i, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_instr = i;
        in_data  = d;
        in_ctrl  = c;
    endtask

    // Monitor: every output transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (reset === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_out: got %0h expected none",
                         {out_instr, out_data, out_ctrl});
            end else begin
                chk("out_payload", {out_instr, out_data, out_ctrl}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [INSTR_W-1:0] iv;

        // Reset held two cycles with traffic offered.
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        send(19'h00777, 24'h123456, 2'b11);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Streaming, one per cycle, latency 1.
        for (int k = 1; k <= 5; k++) begin
            iv = INSTR_W'(k);
            send(iv, 24'h100000 + DATA_W'(k), iv[1:0]);
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_instr", out_instr, k);
        end
        in_valid = 1'b0;
        step();
        chk("stream_done_valid", out_valid, 0);

        // Stall with held payload.
        send(19'h0AAAA, 24'hABCDEF, 2'b01);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (4) step();
        chk("stall_data", out_data, 24'hABCDEF);
        chk("stall_cnt4", stall_cnt, 4);
`ifdef PIPE_STAGE_SKID_EN
        chk("stall_in_ready", in_ready, 1);
`else
        chk("stall_in_ready", in_ready, 0);
`endif
        send(19'h0BBBB, 24'h135790, 2'b10);
        step();
        in_valid = 1'b0;
        #1;
        chk("stall2_in_ready", in_ready, 0);
        chk("stall2_data", out_data, 24'hABCDEF);
        chk("stall_cnt5", stall_cnt, 5);
        out_ready = 1'b1;
        repeat (3) step();
        chk("stall_drain_valid", out_valid, 0);
        chk("stall_sb_empty", exp_q.size(), 0);

        // Flush with entries held and a transfer offered.
        out_ready = 1'b0;
        send(19'h000A1, 24'hA1A1A1, 2'b00);
        step();
        send(19'h000A2, 24'hA2A2A2, 2'b01);
        step();
        flush = 1'b1;
        send(19'h000F1, 24'hF1F1F1, 2'b11);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_hold_data", out_data, 24'hA1A1A1);
        chk("flush_stall_cnt", stall_cnt, 6);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("flush_no_emit", out_valid, 0);
        end

        // Reset during a stall discards the held transfer.
        out_ready = 1'b0;
        send(19'h7FFFF, 24'h777777, 2'b11);
        step();
        in_valid = 1'b0;
        step();
        chk("rms_stall_cnt", stall_cnt, 7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rms_valid", out_valid, 0);
        chk("rms_instr", out_instr, 0);
        chk("rms_stall_cnt0", stall_cnt, 0);
        chk("rms_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rms_no_emit", out_valid, 0);
        end

        // Counter saturation under a long stall.
        out_ready = 1'b0;
        send(19'h12345, 24'h5A5A5A, 2'b10);
        step();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_hold", stall_cnt, 16'hFFFF);
        chk("sat_data", out_data, 24'h5A5A5A);
        out_ready = 1'b1;
        step();
        step();
        chk("sat_drain_valid", out_valid, 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
